// File: rtl/pc_bcd_encoder_pkg.sv
// pc_bcd_pkg: shared types and constants for the binary-to-BCD encoder slice.
//   state_t        FSM encoding used by pc_bcd_encoder
//   BCD_DIGIT_W    width of one packed BCD digit
//   ADJ_THRESHOLD  digit value at or above which the add-3 correction applies
//   ADJ_ADD        correction added before each shift
package pc_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int                     BCD_DIGIT_W   = 4;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESHOLD = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD       = 4'd3;

endpackage

// File: rtl/pc_bcd_encoder_if.sv
// pc_bcd_encoder_if: request/result bundle between the PC value source and the encoder.
//   START  request a conversion (value source -> encoder)
//   DIN    binary value to convert (value source -> encoder)
//   BUSY   conversion in progress or result cycle (encoder -> consumers)
//   DONE   one-cycle result strobe (encoder -> consumers)
//   BCD    packed decimal digits, units at [3:0] (encoder -> consumers)
//   OVF    value did not fit in DIGITS digits (encoder -> consumers)
//   BLANK  per-digit leading-zero mask (encoder -> consumers)
// Modports: master = value source / consumers, slave = encoder.
interface pc_bcd_encoder_if #(
    parameter int DIN_W  = 32,
    parameter int DIGITS = 10
) ();

    logic                  START;
    logic [DIN_W-1:0]      DIN;
    logic                  BUSY;
    logic                  DONE;
    logic [4*DIGITS-1:0]   BCD;
    logic                  OVF;
    logic [DIGITS-1:0]     BLANK;

    modport master (
        output START, DIN,
        input  BUSY, DONE, BCD, OVF, BLANK
    );

    modport slave (
        input  START, DIN,
        output BUSY, DONE, BCD, OVF, BLANK
    );

endinterface

// File: rtl/pc_bcd_encoder_bcd_digit_adj.sv
// bcd_digit_adj: combinational add-3 correction for one BCD digit.
//   din   current digit value (0-9)
//   dout  din + 3 when din >= 5, else din; doubling dout yields the decimal carry in bit 3
module bcd_digit_adj
    import pc_bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    assign dout = (din >= ADJ_THRESHOLD) ? din + ADJ_ADD : din;

endmodule

// File: rtl/pc_bcd_encoder.sv
// pc_bcd_encoder: sequential double-dabble binary-to-BCD converter feeding the
// 7-segment decoder bank. One algorithm iteration per SHIFT cycle, DIN_W iterations.
//   CLK   system clock, rising edge
//   nRST  synchronous active-low reset
//   bus   pc_bcd_encoder_if.slave (START, DIN in; BUSY, DONE, BCD, OVF, BLANK out)
// Build option: define PC_BCD_ENCODER_LEADING_ZERO_BLANK_EN to generate the
// leading-zero BLANK mask; otherwise BLANK is tied to zero.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for START; result registers hold last conversion
// SHIFT | one add-3 + shift iteration per cycle, DIN_W cycles
// DONE  | one-cycle result strobe, then back to IDLE
module pc_bcd_encoder
    import pc_bcd_pkg::*;
#(
    parameter int DIN_W  = 32,
    parameter int DIGITS = 10
) (
    input logic               CLK,
    input logic               nRST,
    pc_bcd_encoder_if.slave   bus
);

    localparam int                SCR_W    = BCD_DIGIT_W * DIGITS;
    localparam int                CNT_W    = (DIN_W > 1) ? $clog2(DIN_W) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIN_W - 1);

    state_t             state_q, state_d;
    logic [DIN_W-1:0]   shreg_q, shreg_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sticky_q, sticky_d;
    logic [SCR_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;

    logic [SCR_W-1:0]   adj;
    logic [SCR_W-1:0]   scratch_sh;
    logic [DIN_W-1:0]   shreg_sh;
    logic               carry_out;
    logic               last_iter;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // {scratch, shreg} << 1 after correction; the bit leaving the top digit is
    // a decimal carry past the last digit, i.e. overflow.
    assign scratch_sh = {adj[SCR_W-2:0], shreg_q[DIN_W-1]};
    assign shreg_sh   = {shreg_q[DIN_W-2:0], 1'b0};
    assign carry_out  = adj[SCR_W-1];
    assign last_iter  = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            sticky_q  <= sticky_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        sticky_d  = sticky_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    state_d   = SHIFT;
                    shreg_d   = bus.DIN;
                    scratch_d = '0;
                    cnt_d     = '0;
                    sticky_d  = 1'b0;
                end
            end
            SHIFT: begin
                shreg_d   = shreg_sh;
                scratch_d = scratch_sh;
                sticky_d  = sticky_q | carry_out;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    // Result taken from the last iteration directly, not from
                    // scratch_q, so no extra correction follows the final shift.
                    bcd_d   = scratch_sh;
                    ovf_d   = sticky_q | carry_out;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.BUSY = (state_q == SHIFT) || (state_q == DONE);
    assign bus.DONE = (state_q == DONE);
    assign bus.BCD  = bcd_q;
    assign bus.OVF  = ovf_q;

`ifdef PC_BCD_ENCODER_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_q;
    logic [DIGITS-1:0] blank_fin;

    // Digit i is blanked when it and every digit above it are zero; the units
    // digit is never blanked so a zero value still shows "0".
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_fin  = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_above   = zero_above & (scratch_sh[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            blank_fin[i] = zero_above;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            blank_q <= ~DIGITS'(1);
        end else if (last_iter) begin
            blank_q <= blank_fin;
        end
    end

    assign bus.BLANK = blank_q;
`else
    assign bus.BLANK = '0;
`endif

endmodule
